ppu_loader: RTL and testbench

PPU_LOADER -- requirements
Module: ppu_loader

---
 rtl/ppu_pkg.sv | 18 +
 rtl/ppu_cfg_regfile.sv | 33 +++
 rtl/ppu_loader.sv | 147 ++++++++++++++
 tb/tb_ppu_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared types and constants for the ppu config loader
// Contents: loader state enum, ppu mode/data widths, default table depth.
package ppu_pkg;

    localparam int PPU_MODE_W = 3;
    localparam int PPU_DATA_W = 8;
    localparam int NBYTES_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_SYNC       = 3'd2,
        ST_SEND       = 3'd3,
        ST_RUN        = 3'd4,
        ST_ERR        = 3'd5
    } ppu_state_t;

endpackage

// File: rtl/ppu_cfg_regfile.sv
// rtl/ppu_cfg_regfile.sv - NBYTES x 8 config byte table, one write port, one async read port
// Ports: clk_pix/rst_pix_n clock and async active-low reset (contents cleared),
//        we/waddr/wdata write port, raddr/rdata combinational read port.
module ppu_cfg_regfile
    import ppu_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
) (
    input  logic                  clk_pix,
    input  logic                  rst_pix_n,
    input  logic                  we,
    input  logic [3:0]            waddr,
    input  logic [PPU_DATA_W-1:0] wdata,
    input  logic [3:0]            raddr,
    output logic [PPU_DATA_W-1:0] rdata
);

    logic [PPU_DATA_W-1:0] mem [NBYTES];

    // The caller guarantees waddr/raddr are below NBYTES.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            for (int i = 0; i < NBYTES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ppu_loader.sv
// rtl/ppu_loader.sv - streams a config byte table to the ppu at a frame boundary
// Ports: clk_pix/rst_pix_n clock and async active-low reset; start load request;
//        frame_start frame boundary pulse; cfg_we/cfg_addr/cfg_wdata table write;
//        cfg_mode mode applied at the next load; ppu_sync/ppu_mode/ppu_data/ppu_stb
//        ppu config stream with ppu_ack handshake; busy/running/err status.
// Optional: PPU_LOADER_TIMEOUT_EN enables the ack timeout and the ERR state.
module ppu_loader
    import ppu_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF,
    parameter int TMO_W  = 8
) (
    input  logic                  clk_pix,
    input  logic                  rst_pix_n,
    input  logic                  start,
    input  logic                  frame_start,
    input  logic                  cfg_we,
    input  logic [3:0]            cfg_addr,
    input  logic [PPU_DATA_W-1:0] cfg_wdata,
    input  logic [PPU_MODE_W-1:0] cfg_mode,
    output logic                  ppu_sync,
    output logic [PPU_MODE_W-1:0] ppu_mode,
    output logic [PPU_DATA_W-1:0] ppu_data,
    output logic                  ppu_stb,
    input  logic                  ppu_ack,
    output logic                  busy,
    output logic                  running,
    output logic                  err
);

    if (NBYTES < 2 || NBYTES > 16 || TMO_W < 2) begin : g_bad_param
        $error("ppu_loader: NBYTES must be 2..16 and TMO_W at least 2");
    end

    localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

    ppu_state_t            state, state_nxt;
    logic [3:0]            idx, idx_nxt;
    logic [PPU_MODE_W-1:0] mode_nxt;
    logic [PPU_DATA_W-1:0] tbl_rdata;
    logic                  tbl_we;
    logic                  tmo_hit;

    // The table is frozen for the whole load so the streamed bytes are consistent.
    assign tbl_we = cfg_we && !busy && ({1'b0, cfg_addr} < 5'(NBYTES));

    ppu_cfg_regfile #(.NBYTES(NBYTES)) u_tbl (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .we        (tbl_we),
        .waddr     (cfg_addr),
        .wdata     (cfg_wdata),
        .raddr     (idx),
        .rdata     (tbl_rdata)
    );

`ifdef PPU_LOADER_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);
    logic [TMO_W-1:0] tmo_cnt;

    // The stall that would bring the count to all-ones is the one that trips ERR.
    assign tmo_hit = (state == ST_SEND) && !ppu_ack && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (state == ST_SEND && !ppu_ack && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
            err <= (state_nxt == ST_ERR);
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            ppu_mode <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            ppu_mode <= mode_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        mode_nxt  = ppu_mode;
        ppu_sync  = 1'b0;
        ppu_stb   = 1'b0;
        ppu_data  = '0;
        busy      = 1'b0;
        running   = 1'b0;
        case (state)
            ST_IDLE, ST_RUN, ST_ERR: begin
                running = (state == ST_RUN);
                if (start) begin
                    state_nxt = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_FRAME: begin
                busy = 1'b1;
                if (frame_start) begin
                    state_nxt = ST_SYNC;
                    mode_nxt  = cfg_mode;
                end
            end
            ST_SYNC: begin
                busy      = 1'b1;
                ppu_sync  = 1'b1;
                state_nxt = ST_SEND;
                idx_nxt   = '0;
            end
            ST_SEND: begin
                busy     = 1'b1;
                ppu_sync = 1'b1;
                ppu_stb  = 1'b1;
                ppu_data = tbl_rdata;
                if (ppu_ack) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_RUN;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end else if (tmo_hit) begin
                    state_nxt = ST_ERR;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ppu_loader.sv
// tb/tb_ppu_loader.sv - self-checking bench for ppu_loader with a byte scoreboard
module tb_ppu_loader;

`ifdef PPU_LOADER_TIMEOUT_EN
    localparam int TB_TMO_W = 4;
`else
    localparam int TB_TMO_W = 8;
`endif

    logic       clk_pix = 1'b0;
    logic       rst_pix_n = 1'b0;
    logic       start = 1'b0;
    logic       frame_start = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;
    logic [2:0] cfg_mode = '0;
    logic       ppu_ack = 1'b0;
    logic       ppu_sync;
    logic [2:0] ppu_mode;
    logic [7:0] ppu_data;
    logic       ppu_stb;
    logic       busy;
    logic       running;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] tbl [10] = '{8'd42, 8'd123, 8'd87, 8'd255, 8'd0, 8'd198, 8'd76, 8'd34, 8'd210, 8'hB6};

    ppu_loader #(.NBYTES(10), .TMO_W(TB_TMO_W)) dut (
        .clk_pix     (clk_pix),
        .rst_pix_n   (rst_pix_n),
        .start       (start),
        .frame_start (frame_start),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_mode    (cfg_mode),
        .ppu_sync    (ppu_sync),
        .ppu_mode    (ppu_mode),
        .ppu_data    (ppu_data),
        .ppu_stb     (ppu_stb),
        .ppu_ack     (ppu_ack),
        .busy        (busy),
        .running     (running),
        .err         (err)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic wait_running(input int max);
        int n = 0;
        while (running !== 1'b1 && n < max) begin
            @(negedge clk_pix);
            n++;
        end
        chk("run_reached", running, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {ppu_sync, ppu_stb, ppu_data, ppu_mode, busy, running, err}, 0);
    endtask

    // Every accepted byte must be the next one the bench scheduled.
    always @(negedge clk_pix) begin
        if (rst_pix_n && ppu_stb && ppu_ack) begin
            if (exp_q.size() == 0) chk("stb_unexpected", 1, 0);
            else chk("byte", ppu_data, exp_q.pop_front());
        end
    end

    initial begin
        #3;
        chk_reset_outputs("reset_state");
        #20;
        @(negedge clk_pix);
        rst_pix_n = 1'b1;

        // Table fill plus an out-of-range write that must be dropped.
        for (int i = 0; i < 10; i++) begin
            cfg_we = 1'b1; cfg_addr = 4'(i); cfg_wdata = tbl[i];
            tick();
        end
        cfg_addr = 4'd12; cfg_wdata = 8'h99;
        tick();
        cfg_we = 1'b0;
        @(negedge clk_pix);
        chk("idle_busy", busy, 0);

        // Load 1: ack always high.
        cfg_mode = 3'd3; ppu_ack = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk_pix);
        chk("wait_busy", busy, 1);
        chk("wait_quiet", {ppu_sync, ppu_stb}, 0);
        for (int i = 0; i < 10; i++) exp_q.push_back(tbl[i]);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        @(negedge clk_pix);
        chk("sync_alone", {ppu_sync, ppu_stb}, 2'b10);
        chk("mode_3", ppu_mode, 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_pix);
            chk("stb_burst", {ppu_sync, ppu_stb}, 2'b11);
        end
        @(negedge clk_pix);
        chk("run_1", running, 1);
        chk("run_quiet", {ppu_sync, ppu_stb}, 0);
        chk("q_empty_1", exp_q.size(), 0);
        repeat (2) begin
            @(negedge clk_pix);
            chk("ack_ignored_run", ppu_stb, 0);
        end

        // Load 2: reload from RUN, late frame_start, stall on byte 2, write during SEND.
        cfg_mode = 3'd4; ppu_ack = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_pix);
            chk("no_stb_before_frame", {ppu_sync, ppu_stb}, 0);
        end
        chk("mode_held", ppu_mode, 3);
        for (int i = 0; i < 10; i++) exp_q.push_back(tbl[i]);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        @(negedge clk_pix);
        chk("mode_4", ppu_mode, 4);
        ppu_ack = 1'b1;
        tick();
        tick();
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 8'h11;
        tick();
        cfg_we = 1'b0; ppu_ack = 1'b0;
        repeat (3) begin
            @(negedge clk_pix);
            chk("stall_data", ppu_data, 87);
            chk("stall_stb", ppu_stb, 1);
            @(posedge clk_pix);
        end
        #1;
        ppu_ack = 1'b1;
        @(negedge clk_pix);
        chk("stall_data_4th", ppu_data, 87);
        wait_running(40);
        chk("q_empty_2", exp_q.size(), 0);

        // Load 3: dropped writes left byte 0 at 42; reset at byte 5.
        cfg_mode = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) exp_q.push_back(tbl[i]);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (6) tick();
        chk("at_byte5", ppu_data, 198);
        #2;
        rst_pix_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        chk("q_empty_3", exp_q.size(), 0);
        @(negedge clk_pix);
        chk_reset_outputs("reset_hold");
        rst_pix_n = 1'b1;

        // Load 4: table cleared by reset; write and start on the same cycle.
        cfg_we = 1'b1; cfg_addr = 4'd3; cfg_wdata = 8'h5A; cfg_mode = 3'd6; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        for (int i = 0; i < 10; i++) exp_q.push_back((i == 3) ? 8'h5A : 8'h00);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        @(negedge clk_pix);
        chk("mode_6", ppu_mode, 6);
        wait_running(40);
        chk("q_empty_4", exp_q.size(), 0);

`ifdef PPU_LOADER_TIMEOUT_EN
        begin
            int n = 0;
            ppu_ack = 1'b0; start = 1'b1;
            tick();
            start = 1'b0;
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            while (n < 100) begin
                @(negedge clk_pix);
                if (err === 1'b1) break;
                if (ppu_stb === 1'b1) n++;
            end
            chk("tmo_cycles", n, 15);
            chk("tmo_err", err, 1);
            chk("tmo_quiet", {ppu_sync, ppu_stb}, 0);
            start = 1'b1;
            tick();
            start = 1'b0;
            @(negedge clk_pix);
            chk("tmo_err_cleared", err, 0);
            chk("tmo_restart_busy", busy, 1);
        end
`else
        chk("err_tied", err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
